// File: rtl/cdf_controller.sv
// Sequencing FSM for cdf_datapath. A single start pulse walks the whole
// histogram eight bins at a time: each iteration issues the reads, waits
// out the memory latency, then strobes the two CDF word writes. A final
// cdf_done step and a one-cycle done pulse close the pass. abort returns
// the block to IDLE from any active state without pulsing done.
module cdf_controller #(
    parameter int NUM_BINS    = 256,
    parameter int WAIT_CYCLES = 2,
    localparam int NITER      = NUM_BINS / 8,
    localparam int ITER_W     = (NITER > 1) ? $clog2(NITER) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              read_first_value,
    output logic              scratch_mem_read_ready,
    output logic              cdf_computation_done,
    output logic              read_next_value,
    output logic              cdf_done,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_COMPUTE,
        ST_WRITE_LO,
        ST_WRITE_HI,
        ST_ADVANCE,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NITER - 1);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic rfv_q, rfv_d;
    logic smrr_q, smrr_d;
    logic ccd_q, ccd_d;
    logic rnv_q, rnv_d;
    logic cdfd_q, cdfd_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Next state, wait countdown and iteration index; abort overrides everything once active.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        iter_d     = iter_q;
        if (state_q != ST_IDLE && abort) begin
            state_d    = ST_IDLE;
            wait_cnt_d = 4'd0;
            iter_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d = ST_INIT;
                        iter_d  = '0;
                    end
                end
                ST_INIT: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                    iter_d     = '0;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_d = ST_COMPUTE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end
                ST_COMPUTE:  state_d = ST_WRITE_LO;
                ST_WRITE_LO: state_d = ST_WRITE_HI;
                ST_WRITE_HI: begin
                    if (iter_q == LAST_ITER) begin
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                    iter_d     = iter_q + ITER_W'(1);
                end
                ST_FINAL: state_d = ST_DONE;
                ST_DONE: begin
                    state_d = ST_IDLE;
                    iter_d  = '0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                    iter_d     = '0;
                end
            endcase
        end
    end

    // Moore decode of the upcoming state so every output comes straight from a flop.
    always_comb begin
        rfv_d  = (state_d == ST_INIT);
        smrr_d = (state_d == ST_COMPUTE);
        ccd_d  = (state_d == ST_WRITE_LO);
        rnv_d  = (state_d == ST_WRITE_HI);
        cdfd_d = (state_d == ST_FINAL);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and output flops; reset drops everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            iter_q     <= '0;
            rfv_q      <= 1'b0;
            smrr_q     <= 1'b0;
            ccd_q      <= 1'b0;
            rnv_q      <= 1'b0;
            cdfd_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            iter_q     <= iter_d;
            rfv_q      <= rfv_d;
            smrr_q     <= smrr_d;
            ccd_q      <= ccd_d;
            rnv_q      <= rnv_d;
            cdfd_q     <= cdfd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign read_first_value       = rfv_q;
    assign scratch_mem_read_ready = smrr_q;
    assign cdf_computation_done   = ccd_q;
    assign read_next_value        = rnv_q;
    assign cdf_done               = cdfd_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign iter_count             = iter_q;

endmodule

// File: tb/tb_cdf_controller.sv
// Bench for cdf_controller. Three instances with different geometry
// (default, WAIT_CYCLES=1/NUM_BINS=16, WAIT_CYCLES=3/NUM_BINS=8) run side
// by side. The reference model only remembers whether a pass is running
// and the cycle its read_first_value appeared; the expected strobes are
// computed from the offset into the pass with plain arithmetic.
module tb_cdf_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start_v;
    logic [2:0] abort_v;

    logic [2:0] rfv, smrr, ccd, rnv, cdfd, busy, done;
    logic [4:0] iterA;
    logic [0:0] iterB;
    logic [0:0] iterC;

    bit act [3];
    int t0  [3];
    int nit [3];
    int wc  [3];

    int cyc;
    int compared;
    int mismatched;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    cdf_controller #(.NUM_BINS(256), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
        .read_first_value(rfv[0]), .scratch_mem_read_ready(smrr[0]),
        .cdf_computation_done(ccd[0]), .read_next_value(rnv[0]),
        .cdf_done(cdfd[0]), .busy(busy[0]), .done(done[0]), .iter_count(iterA)
    );

    cdf_controller #(.NUM_BINS(16), .WAIT_CYCLES(1)) dutB (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
        .read_first_value(rfv[1]), .scratch_mem_read_ready(smrr[1]),
        .cdf_computation_done(ccd[1]), .read_next_value(rnv[1]),
        .cdf_done(cdfd[1]), .busy(busy[1]), .done(done[1]), .iter_count(iterB)
    );

    cdf_controller #(.NUM_BINS(8), .WAIT_CYCLES(3)) dutC (
        .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]),
        .read_first_value(rfv[2]), .scratch_mem_read_ready(smrr[2]),
        .cdf_computation_done(ccd[2]), .read_next_value(rnv[2]),
        .cdf_done(cdfd[2]), .busy(busy[2]), .done(done[2]), .iter_count(iterC)
    );

    // Bit layout: 15 rfv, 14 smrr, 13 ccd, 12 rnv, 11 cdf_done, 10 busy, 9 done, 7:0 iter.
    function automatic logic [15:0] observed(int idx);
        logic [7:0] it;
        case (idx)
            0:       it = 8'(iterA);
            1:       it = 8'(iterB);
            default: it = 8'(iterC);
        endcase
        return {rfv[idx], smrr[idx], ccd[idx], rnv[idx], cdfd[idx],
                busy[idx], done[idx], 1'b0, it};
    endfunction

    function automatic int passLength(int idx);
        return nit[idx] * (wc[idx] + 4) + 1;
    endfunction

    // Expected outputs from the offset into the pass: each iteration is
    // WAIT_CYCLES waits, compute, write lo, write hi, advance; the last
    // iteration skips advance and is followed by cdf_done then done.
    function automatic logic [15:0] expected(int idx);
        logic [15:0] e;
        int d, total, k, r;
        e = 16'h0;
        if (act[idx]) begin
            d     = cyc - t0[idx];
            total = passLength(idx);
            e[10] = 1'b1;
            if (d == 0) begin
                e[15] = 1'b1;
            end else if (d <= total - 2) begin
                k = (d - 1) / (wc[idx] + 4);
                r = (d - 1) % (wc[idx] + 4);
                e[7:0] = 8'(k);
                if (r == wc[idx])          e[14] = 1'b1;
                else if (r == wc[idx] + 1) e[13] = 1'b1;
                else if (r == wc[idx] + 2) e[12] = 1'b1;
            end else if (d == total - 1) begin
                e[11]  = 1'b1;
                e[7:0] = 8'(nit[idx] - 1);
            end else begin
                e[9]   = 1'b1;
                e[7:0] = 8'(nit[idx] - 1);
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check all instances, drive inputs, advance the model at the edge.
    task automatic applyStimulus(input logic [2:0] st, input logic [2:0] ab);
        logic [15:0] o;
        int d;
        for (int i = 0; i < 3; i++) begin
            o = observed(i);
            if (!act[i]) o[7:0] = 8'h0;
            checkOutput($sformatf("dut%0d outputs", i), o, expected(i));
        end
        start_v = st;
        abort_v = ab;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (act[i]) begin
                d = cyc - t0[i];
                if (ab[i] || d == passLength(i)) act[i] = 1'b0;
            end else if (st[i] && !ab[i]) begin
                act[i] = 1'b1;
                t0[i]  = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        start_v    = 3'b000;
        abort_v    = 3'b000;
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        nit        = '{32, 2, 1};
        wc         = '{2, 1, 3};
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            t0[i]  = 0;
        end

        // Reset state: every output and iter_count must be zero.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("dut%0d reset", i), observed(i), 16'h0);
        reset = 1'b1;

        // Single-cycle start on all instances, run to completion.
        applyStimulus(3'b111, 3'b000);
        repeat (200) applyStimulus(3'b000, 3'b000);

        // Start held high: one pass at a time, restart right after IDLE.
        repeat (300) applyStimulus(3'b111, 3'b000);
        repeat (200) applyStimulus(3'b000, 3'b000);

        // Abort in iteration 5 WRITE_LO (T+34), then a fresh start.
        applyStimulus(3'b001, 3'b000);
        repeat (34) applyStimulus(3'b000, 3'b000);
        applyStimulus(3'b000, 3'b001);
        repeat (5) applyStimulus(3'b000, 3'b000);
        applyStimulus(3'b001, 3'b000);
        repeat (10) applyStimulus(3'b000, 3'b000);
        applyStimulus(3'b000, 3'b001);
        repeat (3) applyStimulus(3'b000, 3'b000);

        // start and abort together in IDLE: nothing happens.
        applyStimulus(3'b111, 3'b111);
        repeat (5) applyStimulus(3'b000, 3'b000);

        // Asynchronous reset in the middle of WAIT, between clock edges.
        applyStimulus(3'b001, 3'b000);
        applyStimulus(3'b000, 3'b000);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) act[i] = 1'b0;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("dut%0d async reset", i), observed(i), 16'h0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) applyStimulus(3'b000, 3'b000);

        // Randomized start/abort traffic on every instance.
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] st, ab;
            for (int i = 0; i < 3; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                ab[i] = ($urandom_range(0, 399) == 0);
            end
            applyStimulus(st, ab);
        end
        repeat (200) applyStimulus(3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cdf_controller.md
Name: cdf_controller

Overview:
- Sequencing FSM for cdf_datapath; generates its five one-cycle control strobes (read_first_value_in, scratch_mem_read_ready_in, cdf_computation_done_in, read_next_value_in, cdf_done_in).
- One start pulse walks the full histogram: each iteration reads 8 bins (two 128-bit scratch words) and writes 8 CDF values (two words). A final cdf_done step follows.
- Sits between the top-level equalization sequencer (start/abort/done) and cdf_datapath.

Parameters:
- NUM_BINS, 256, histogram bins; must be a multiple of 8.
- WAIT_CYCLES, 2, cycles between address issue and data valid at the datapath (memory latency + datapath input flop); legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a CDF pass; sampled only in IDLE.
- abort  input  1  terminate the pass; sampled in every non-IDLE state.
- read_first_value  output  1  to datapath read_first_value_in.
- scratch_mem_read_ready  output  1  to datapath scratch_mem_read_ready_in.
- cdf_computation_done  output  1  to datapath cdf_computation_done_in.
- read_next_value  output  1  to datapath read_next_value_in.
- cdf_done  output  1  to datapath cdf_done_in.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on normal completion.
- iter_count  output  clog2(NUM_BINS/8)  index of the current iteration, 0-based.

Behaviour:
- Reset (reset=0): asynchronous entry to IDLE. All outputs 0, iter_count 0, wait counter 0.
- All outputs are registered and Moore-decoded from the state. At most one of the five datapath strobes is high in any cycle.
- NITER = NUM_BINS/8 (32 by default).
- IDLE:
  - start=1 and abort=0 -> INIT.
  - start=1 with abort=1 -> stay in IDLE.
- INIT (1 cycle): read_first_value=1, iter_count cleared to 0 -> WAIT.
- WAIT (exactly WAIT_CYCLES cycles): no strobes; wait counter counts down -> COMPUTE.
- COMPUTE (1 cycle): scratch_mem_read_ready=1 -> WRITE_LO.
- WRITE_LO (1 cycle): cdf_computation_done=1 (write CDF word 0-3, latch cdf_prev) -> WRITE_HI.
- WRITE_HI (1 cycle): read_next_value=1 (write CDF word 4-7).
  - iter_count == NITER-1 -> FINAL.
  - Otherwise -> ADVANCE.
- ADVANCE (1 cycle): no strobes; the datapath default branch advances the read addresses by 2. iter_count increments at exit -> WAIT.
- FINAL (1 cycle): cdf_done=1 -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- Timing with defaults, read_first_value at cycle T:
  - iteration k: COMPUTE at T+3+6k, WRITE_LO at T+4+6k, WRITE_HI at T+5+6k.
  - last iteration (k=31): COMPUTE T+189, WRITE_LO T+190, WRITE_HI T+191.
  - cdf_done at T+192, done at T+193, IDLE at T+194.
  - General completion: done at T + NITER*(WAIT_CYCLES+4) + 1.
- start while busy: ignored, no restart, no queuing.
- abort=1 in any non-IDLE state:
  - IDLE on the next edge; every output low from that cycle on; done is not pulsed.
  - abort has priority over every other transition, including FINAL->DONE.
- Reset deassertion mid-pass: the block comes up in IDLE and waits for a fresh start.
- iter_count wraps never: the WRITE_HI comparison guarantees it never exceeds NITER-1.
- NUM_BINS=8 (NITER=1): WRITE_HI goes directly to FINAL and ADVANCE is never visited.

Test Plan:
- Reset, then a single-cycle start with defaults:
  - read_first_value exactly 1 cycle at T.
  - 32 each of scratch_mem_read_ready, cdf_computation_done and read_next_value, at T+3+6k, T+4+6k, T+5+6k.
  - cdf_done at T+192, done at T+193, busy low at T+194.
  - Strobes are never simultaneous.
- start held high for 300 cycles: exactly one pass. A new pass begins the cycle after returning to IDLE (read_first_value at T+195). No strobe overlap across passes.
- abort at iteration 5, WRITE_LO (T+34): all outputs 0 from T+35, done never pulses, iter_count 0 after the next start.
- reset driven low asynchronously mid-WAIT (between clock edges): outputs drop immediately without a clock edge. After release, no strobes until start.
- WAIT_CYCLES=1, NUM_BINS=16:
  - COMPUTE at T+2 and T+7.
  - cdf_done at T+10, done at T+11.
  - iter_count reads 0 then 1.
- start and abort asserted together in IDLE: the block stays in IDLE, busy=0, no strobes.
